// File: rtl/gfau_seq_pkg.sv
// Shared definitions for the GFAU program sequencer: sizes, opcode values,
// instruction field layout and the sequencer state encoding.
package gfau_seq_pkg;

    localparam int DATA_W     = 32;
    localparam int RF_DEPTH   = 8;
    localparam int PROG_DEPTH = 16;
    localparam int RF_AW      = 3;
    localparam int PC_W       = 4;
    localparam int LEN_W      = 5;

    localparam int INSTR_W    = 11;
    localparam int OP_LSB     = 9;
    localparam int OP_W       = 2;
    localparam int DST_LSB    = 6;
    localparam int SRC0_LSB   = 3;
    localparam int SRC1_LSB   = 0;
    localparam int REG_W      = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 2'd1;
    localparam logic [OP_W-1:0] OP_MULT = 2'd2;
    localparam logic [OP_W-1:0] OP_DIV  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FIN   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Field order matches the packed instruction word {op, dst, src0, src1}.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] src0;
        logic [REG_W-1:0] src1;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        return instr_t'(raw);
    endfunction

endpackage

// File: rtl/gfau_seq_rf.sv
// 8x32 operand register file: two sequencer read ports, one host read port,
// a single write port, all entries cleared by reset.
module gfau_seq_rf
    import gfau_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              we,
    input  logic [RF_AW-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RF_AW-1:0]  raddr_a,
    input  logic [RF_AW-1:0]  raddr_b,
    input  logic [RF_AW-1:0]  raddr_h,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_h
);

    logic [DATA_W-1:0] regs [RF_DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_h = regs[raddr_h];

endmodule

// File: rtl/gfau_seq.sv
// Runs a host-loaded program of GF(p) operations on a single GFAU instance,
// issuing one operation per instruction and writing the result back.
module gfau_seq
    import gfau_seq_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   prog_len,
    input  logic [DATA_W-1:0]  prime,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               rf_we,
    input  logic [RF_AW-1:0]   rf_waddr,
    input  logic [DATA_W-1:0]  rf_wdata,
    input  logic [RF_AW-1:0]   rf_raddr,
    output logic [DATA_W-1:0]  rf_rdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [DATA_W-1:0]  g_in_0,
    output logic [DATA_W-1:0]  g_in_1,
    output logic [OP_W-1:0]    g_op,
    output logic               g_go,
    input  logic [DATA_W-1:0]  g_result,
    input  logic               g_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [DATA_W-1:0]  in0_q;
    logic [DATA_W-1:0]  in1_q;
    logic [OP_W-1:0]    op_q;
    logic               err_q;
    logic [INSTR_W-1:0] prog_mem [PROG_DEPTH];
    instr_t             cur;
    logic               last_instr;

    logic               rf_we_int;
    logic [RF_AW-1:0]   rf_waddr_int;
    logic [DATA_W-1:0]  rf_wdata_int;
    logic [DATA_W-1:0]  rd_a;
    logic [DATA_W-1:0]  rd_b;

    // The modulus is consumed by the GFAU directly; the sequencer never looks at it.
    logic unused_prime;
    assign unused_prime = ^prime;

    assign cur        = decode_instr(prog_mem[pc]);
    assign last_instr = ({1'b0, pc} + LEN_W'(1)) >= len_q;

    // Instruction store keeps its contents across reset so a program can be rerun.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && state == ST_IDLE && prog_we) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        rf_we_int    = 1'b0;
        rf_waddr_int = rf_waddr;
        rf_wdata_int = rf_wdata;
        if (state == ST_IDLE) begin
            rf_we_int = rf_we;
        end else if (state == ST_WAIT && g_done) begin
            rf_we_int    = 1'b1;
            rf_waddr_int = cur.dst;
            rf_wdata_int = g_result;
        end
    end

    gfau_seq_rf u_rf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .we      (rf_we_int),
        .waddr   (rf_waddr_int),
        .wdata   (rf_wdata_int),
        .raddr_a (cur.src0),
        .raddr_b (cur.src1),
        .raddr_h (rf_raddr),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .rdata_h (rf_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            len_q    <= '0;
            wait_cnt <= '0;
            in0_q    <= '0;
            in1_q    <= '0;
            op_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        len_q <= prog_len;
                        pc    <= '0;
                        state <= (prog_len == '0) ? ST_FIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    in0_q    <= rd_a;
                    in1_q    <= rd_b;
                    op_q     <= cur.op;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (g_done) begin
                        pc    <= pc + PC_W'(1);
                        state <= last_instr ? ST_FIN : ST_ISSUE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operands are presented straight from the register file during ISSUE and
    // from the captured copies afterwards, so the GFAU sees them unchanged in WAIT.
    assign g_in_0 = (state == ST_ISSUE) ? rd_a   : in0_q;
    assign g_in_1 = (state == ST_ISSUE) ? rd_b   : in1_q;
    assign g_op   = (state == ST_ISSUE) ? cur.op : op_q;
    assign g_go   = (state == ST_ISSUE);
    assign busy   = (state == ST_ISSUE) || (state == ST_WAIT);
    assign done   = (state == ST_FIN);
    assign err    = err_q;

endmodule

// File: tb/tb_gfau_seq.sv
// Self-checking bench for gfau_seq: GFAU behavioural model, transaction-level
// sequencer model with a per-cycle compare, and directed program scenarios.
module tb_gfau_seq;
    import gfau_seq_pkg::*;

    localparam int          TO = 256;
    localparam logic [31:0] P  = 32'd23;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  prog_len = '0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [10:0] prog_data = '0;
    logic        rf_we = 1'b0;
    logic [2:0]  rf_waddr = '0;
    logic [31:0] rf_wdata = '0;
    logic [2:0]  rf_raddr = '0;
    logic [31:0] rf_rdata;
    logic        busy, done, err, g_go;
    logic [31:0] g_in_0, g_in_1;
    logic [1:0]  g_op;
    logic [31:0] g_result = '0;
    logic        g_done = 1'b0;

    int checks = 0;
    int failures = 0;

    initial forever #5 i_clk = ~i_clk;

    gfau_seq #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .start(start), .prog_len(prog_len), .prime(P),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .busy(busy), .done(done), .err(err),
        .g_in_0(g_in_0), .g_in_1(g_in_1), .g_op(g_op), .g_go(g_go),
        .g_result(g_result), .g_done(g_done)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Field arithmetic straight from the definition of GF(p).
    function automatic logic [31:0] gfCalc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p, x, y, r, e, base;
        p = 64'(P); x = 64'(a) % p; y = 64'(b) % p;
        case (op)
            2'd0:    r = (x + y) % p;
            2'd1:    r = (x + p - y) % p;
            2'd2:    r = (x * y) % p;
            default: begin
                r = 1; base = y; e = p - 2;
                while (e > 0) begin
                    if (e[0]) r = (r * base) % p;
                    base = (base * base) % p;
                    e = e >> 1;
                end
                r = (x * r) % p;
            end
        endcase
        return r[31:0];
    endfunction

    function automatic logic [10:0] ins(input logic [1:0] op, input logic [2:0] d, input logic [2:0] s0, input logic [2:0] s1);
        return {op, d, s0, s1};
    endfunction

    // GFAU behavioural model: add/sub 1 cycle, mult mult_lat, div div_lat.
    int          mult_lat = 34;
    int          div_lat = 20;
    int          gm_cnt = 0;
    logic [31:0] gm_res = '0;
    initial begin
        forever begin
            @(negedge i_clk);
            if (g_go) begin
                gm_cnt = (g_op == OP_MULT) ? mult_lat : (g_op == OP_DIV) ? div_lat : 1;
                gm_res = gfCalc(g_op, g_in_0, g_in_1);
                g_done = 1'b0;
            end else if (gm_cnt > 0) begin
                gm_cnt--;
                g_done   = (gm_cnt == 0);
                g_result = (gm_cnt == 0) ? gm_res : 32'hDEAD_BEEF;
            end else begin
                g_done = 1'b0;
            end
        end
    end

    // Transaction-level model of the sequencer plus the every-cycle compare.
    logic [31:0] mrf [8];
    logic [10:0] mprog [16];
    bit          m_run = 0, m_go_next = 0, m_done_next = 0, m_err_next = 0;
    bit          m_err_flag = 0, m_just_reset = 0;
    bit          exp_go, exp_done, exp_err_cyc;
    int          m_pc = 0, m_len = 0, m_wait = 0;
    logic [31:0] m_h0 = '0, m_h1 = '0;
    logic [1:0]  m_hop = '0;
    logic [10:0] m_ins;
    int          go_count = 0, done_count = 0;
    logic [31:0] last_go_in0 = '0;

    initial begin
        forever begin
            @(negedge i_clk); #2;
            if (!i_rst_n) begin
                for (int i = 0; i < 8; i++) mrf[i] = '0;
                m_run = 0; m_go_next = 0; m_done_next = 0; m_err_next = 0;
                m_err_flag = 0; m_just_reset = 1;
                m_h0 = '0; m_h1 = '0; m_hop = '0;
            end else begin
                exp_go = m_go_next; exp_done = m_done_next; exp_err_cyc = m_err_next;
                checkOutput("g_go", 32'(g_go), 32'(exp_go));
                checkOutput("done", 32'(done), 32'(exp_done));
                checkOutput("busy", 32'(busy), 32'(m_run));
                checkOutput("err", 32'(err), 32'(m_err_flag));
                if (g_go) begin go_count++; last_go_in0 = g_in_0; end
                if (done) done_count++;
                if (exp_go) begin
                    m_ins = mprog[m_pc];
                    m_hop = m_ins[10:9];
                    m_h0  = mrf[m_ins[5:3]];
                    m_h1  = mrf[m_ins[2:0]];
                    m_wait = 0;
                    checkOutput("issue g_op", 32'(g_op), 32'(m_hop));
                    checkOutput("issue g_in_0", g_in_0, m_h0);
                    checkOutput("issue g_in_1", g_in_1, m_h1);
                end else if (m_run || m_just_reset) begin
                    checkOutput("hold g_op", 32'(g_op), 32'(m_hop));
                    checkOutput("hold g_in_0", g_in_0, m_h0);
                    checkOutput("hold g_in_1", g_in_1, m_h1);
                end
                m_just_reset = 0;
                m_go_next = 0; m_done_next = 0; m_err_next = 0;
                if (!m_run && !exp_done && !exp_err_cyc) begin
                    if (rf_we) mrf[rf_waddr] = rf_wdata;
                    if (prog_we) mprog[prog_addr] = prog_data;
                    if (start) begin
                        m_err_flag = 0;
                        if (prog_len == 0) m_done_next = 1;
                        else begin m_run = 1; m_pc = 0; m_len = int'(prog_len); m_go_next = 1; end
                    end
                end else if (m_run && !exp_go) begin
                    m_wait++;
                    if (g_done) begin
                        mrf[m_ins[8:6]] = gfCalc(m_hop, m_h0, m_h1);
                        m_pc++;
                        if (m_pc < m_len) m_go_next = 1;
                        else begin m_run = 0; m_done_next = 1; end
                    end else if (m_wait == TO) begin
                        m_run = 0; m_err_next = 1; m_err_flag = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic sampleTick();
        @(negedge i_clk); #2;
    endtask

    task automatic hostReg(input logic [2:0] a, input logic [31:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        tick();
        rf_we = 1'b0;
    endtask

    task automatic hostProg(input logic [3:0] a, input logic [10:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic readReg(input logic [2:0] a, input logic [31:0] exp, input string name);
        rf_raddr = a;
        sampleTick();
        checkOutput(name, rf_rdata, exp);
        tick();
    endtask

    task automatic doReset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
    endtask

    // Starts a program and returns the number of cycles until done is seen.
    task automatic applyStimulus(input logic [4:0] len, input int maxc, output int n);
        start = 1'b1; prog_len = len;
        tick();
        start = 1'b0;
        n = 0;
        for (int k = 1; k <= maxc; k++) begin
            sampleTick();
            if (done) begin n = k; break; end
        end
        if (n == 0) checkOutput("done within budget", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, g0, d0;
        i_rst_n = 1'b0;
        tick(); tick();
        i_rst_n = 1'b1;
        readReg(3'd0, 32'd0, "reset rf0");
        readReg(3'd7, 32'd0, "reset rf7");

        // add r2 = r0 + r1 : (20 + 5) mod 23 = 2
        hostReg(3'd0, 32'd20); hostReg(3'd1, 32'd5);
        hostProg(4'd0, ins(OP_ADD, 3'd2, 3'd0, 3'd1));
        g0 = go_count; d0 = done_count;
        applyStimulus(5'd1, 20, n);
        checkOutput("add done latency", 32'(n), 32'd3);
        checkOutput("add go count", 32'(go_count - g0), 32'd1);
        readReg(3'd2, 32'd2, "add rf2");

        // sub r3 = 3 - 7 = 19 ; add r3 = 19 + 19 = 15
        hostReg(3'd0, 32'd3); hostReg(3'd1, 32'd7);
        hostProg(4'd0, ins(OP_SUB, 3'd3, 3'd0, 3'd1));
        hostProg(4'd1, ins(OP_ADD, 3'd3, 3'd3, 3'd3));
        g0 = go_count; d0 = done_count;
        applyStimulus(5'd2, 20, n);
        checkOutput("two-step go count", 32'(go_count - g0), 32'd2);
        checkOutput("two-step done count", 32'(done_count - d0), 32'd1);
        checkOutput("step1 operand rf3", last_go_in0, 32'd19);
        readReg(3'd3, 32'd15, "two-step rf3");

        // mult r6 = 6 * 9 = 54 mod 23 = 8, 34-cycle GFAU latency
        hostReg(3'd4, 32'd6); hostReg(3'd5, 32'd9);
        hostProg(4'd0, ins(OP_MULT, 3'd6, 3'd4, 3'd5));
        applyStimulus(5'd1, 60, n);
        checkOutput("mult done latency", 32'(n), 32'd36);
        readReg(3'd6, 32'd8, "mult rf6");

        // div whose latency exceeds the timeout
        div_lat = 300;
        hostProg(4'd0, ins(OP_DIV, 3'd7, 3'd4, 3'd5));
        start = 1'b1; prog_len = 5'd1;
        tick();
        start = 1'b0;
        n = 0;
        for (int k = 1; k <= 400; k++) begin
            sampleTick();
            if (err) begin n = k; break; end
        end
        checkOutput("timeout err cycle", 32'(n), 32'd258);
        checkOutput("err cycle busy", 32'(busy), 32'd0);
        tick();
        sampleTick();
        checkOutput("err sticky", 32'(err), 32'd1);
        tick();
        readReg(3'd7, 32'd0, "timeout dst unchanged");
        for (int k = 0; k < 60; k++) tick();
        div_lat = 20;
        hostProg(4'd0, ins(OP_ADD, 3'd2, 3'd0, 3'd1));
        applyStimulus(5'd1, 20, n);
        checkOutput("err cleared by start", 32'(err), 32'd0);
        readReg(3'd2, 32'd10, "post-err add rf2");

        // reset in the middle of a 3-instruction program
        hostProg(4'd0, ins(OP_MULT, 3'd6, 3'd4, 3'd5));
        hostProg(4'd1, ins(OP_MULT, 3'd6, 3'd6, 3'd5));
        hostProg(4'd2, ins(OP_MULT, 3'd7, 3'd6, 3'd4));
        hostReg(3'd6, 32'd1);
        start = 1'b1; prog_len = 5'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        d0 = done_count;
        doReset();
        sampleTick();
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst g_go", 32'(g_go), 32'd0);
        checkOutput("rst g_in_0", g_in_0, 32'd0);
        checkOutput("rst g_op", 32'(g_op), 32'd0);
        tick();
        for (int k = 0; k < 40; k++) tick();
        checkOutput("no done after rst", 32'(done_count - d0), 32'd0);
        readReg(3'd6, 32'd0, "rst rf6 zero");
        readReg(3'd4, 32'd0, "rst rf4 zero");

        // zero-length program
        g0 = go_count;
        applyStimulus(5'd0, 10, n);
        checkOutput("len0 done latency", 32'(n), 32'd1);
        checkOutput("len0 no go", 32'(go_count - g0), 32'd0);

        // start, rf_we and prog_we while busy are ignored: mult r2 = 4*5 = 20
        hostReg(3'd0, 32'd4); hostReg(3'd1, 32'd5);
        hostProg(4'd0, ins(OP_MULT, 3'd2, 3'd0, 3'd1));
        g0 = go_count; d0 = done_count;
        start = 1'b1; prog_len = 5'd1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; rf_we = 1'b1; rf_waddr = 3'd0; rf_wdata = 32'd11;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = ins(OP_ADD, 3'd2, 3'd0, 3'd1);
        tick();
        start = 1'b0; rf_we = 1'b0; prog_we = 1'b0;
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            sampleTick();
            if (done) begin n = k; break; end
        end
        checkOutput("busy run completes", 32'(n != 0), 32'd1);
        tick();
        checkOutput("busy run go count", 32'(go_count - g0), 32'd1);
        checkOutput("busy run done count", 32'(done_count - d0), 32'd1);
        readReg(3'd0, 32'd4, "rf_we ignored while busy");
        readReg(3'd2, 32'd20, "busy run rf2");
        applyStimulus(5'd1, 60, n);
        checkOutput("prog_we ignored while busy", 32'(n), 32'd36);

        for (int k = 0; k < 3; k++) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
